// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side LFSR pattern checker. Seeds its own register from the
// first DATAWIDTH stream bits, then flywheels the prediction and compares each bit.
// Reports lock state, per-bit error pulses, lock-loss pulses and a saturating error count.
module lfsr_checker #(
  parameter int DATAWIDTH = 10,
  parameter int CNT_W     = 16,
  parameter int WINDOW    = 64,
  parameter int ERR_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 en,
  input  logic [DATAWIDTH-1:0] polynomial,
  input  logic                 din,
  input  logic                 clr,
  output logic                 locked,
  output logic                 bit_err,
  output logic                 lock_lost,
  output logic [CNT_W-1:0]     err_count
);

  localparam int SC_W = $clog2(DATAWIDTH + 1);
  localparam int WC_W = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {IDLE, SEED, LOCKED} state_t;

  state_t               state, state_next;
  logic                 load_q;
  logic [DATAWIDTH-1:0] poly, poly_next;
  logic [DATAWIDTH-1:0] shreg, shreg_next;
  logic [SC_W-1:0]      seed_cnt, seed_cnt_next, seed_inc;
  logic [WC_W-1:0]      win_cnt, win_cnt_next, win_cnt_inc;
  logic [WC_W-1:0]      win_err, win_err_next, win_err_inc;
  logic                 locked_next, bit_err_next, lock_lost_next;
  logic [CNT_W-1:0]     err_count_next;
  logic                 load_edge;
  logic                 exp_bit;
  logic                 mismatch;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, flywheel prediction, window monitor and error counting
  always_comb begin
    state_next     = state;
    poly_next      = poly;
    shreg_next     = shreg;
    seed_cnt_next  = seed_cnt;
    win_cnt_next   = win_cnt;
    win_err_next   = win_err;
    bit_err_next   = 1'b0;
    lock_lost_next = 1'b0;
    mismatch       = 1'b0;
    seed_inc       = seed_cnt + 1'b1;
    win_cnt_inc    = win_cnt + 1'b1;
    win_err_inc    = win_err;
    load_edge      = load & ~load_q;
    exp_bit        = ^(poly & shreg);

    if (load_edge) begin
      // A load edge wins over en; the din of this cycle is dropped
      poly_next     = polynomial;
      shreg_next    = '0;
      seed_cnt_next = '0;
      win_cnt_next  = '0;
      win_err_next  = '0;
      state_next    = (polynomial == '0) ? IDLE : SEED;
    end else if (en) begin
      case (state)
        SEED: begin
          shreg_next    = {shreg[DATAWIDTH-2:0], din};
          seed_cnt_next = seed_inc;
          if (int'(seed_inc) == DATAWIDTH) state_next = LOCKED;
        end
        LOCKED: begin
          // Prediction is fed back, not din, so a flipped bit is one error only
          mismatch     = din ^ exp_bit;
          shreg_next   = {shreg[DATAWIDTH-2:0], exp_bit};
          bit_err_next = mismatch;
          win_err_inc  = win_err + WC_W'(mismatch);
          if (ERR_LIMIT != 0 && int'(win_err_inc) == ERR_LIMIT) begin
            state_next     = SEED;
            seed_cnt_next  = '0;
            shreg_next     = '0;
            win_cnt_next   = '0;
            win_err_next   = '0;
            lock_lost_next = 1'b1;
          end else if (int'(win_cnt_inc) == WINDOW) begin
            win_cnt_next = '0;
            win_err_next = '0;
          end else begin
            win_cnt_next = win_cnt_inc;
            win_err_next = win_err_inc;
          end
        end
        default: ;
      endcase
    end

    locked_next = (state_next == LOCKED);

    if (clr) begin
      err_count_next = CNT_W'(mismatch);
    end else if (mismatch && err_count != '1) begin
      err_count_next = err_count + 1'b1;
    end else begin
      err_count_next = err_count;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q    <= 1'b0;
      poly      <= '0;
      shreg     <= '0;
      seed_cnt  <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      bit_err   <= 1'b0;
      lock_lost <= 1'b0;
      err_count <= '0;
    end else begin
      load_q    <= load;
      poly      <= poly_next;
      shreg     <= shreg_next;
      seed_cnt  <= seed_cnt_next;
      win_cnt   <= win_cnt_next;
      win_err   <= win_err_next;
      locked    <= locked_next;
      bit_err   <= bit_err_next;
      lock_lost <= lock_lost_next;
      err_count <= err_count_next;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed checks of lfsr_checker against a bench-side generator.
module tb_lfsr_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       load, en, din, clr;
  logic [9:0] polynomial;
  logic       locked, bit_err, lock_lost;
  logic [15:0] err_count;
  logic       locked2, bit_err2, lock_lost2;
  logic [3:0] err_count2;

  int n_checks = 0;
  int n_fail   = 0;
  int be_cnt, lost_cnt;
  logic [9:0] gen_state;

  lfsr_checker #(.DATAWIDTH(10), .CNT_W(16), .WINDOW(64), .ERR_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .load(load), .en(en), .polynomial(polynomial), .din(din),
    .clr(clr), .locked(locked), .bit_err(bit_err), .lock_lost(lock_lost),
    .err_count(err_count)
  );

  lfsr_checker #(.DATAWIDTH(10), .CNT_W(4), .WINDOW(64), .ERR_LIMIT(0)) dut2 (
    .clk(clk), .rst(rst), .load(load), .en(en), .polynomial(polynomial), .din(din),
    .clr(clr), .locked(locked2), .bit_err(bit_err2), .lock_lost(lock_lost2),
    .err_count(err_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    nbits;
    int    f0, f1, f2, f3;
    int    exp_err;
    int    exp_bit_err;
    int    exp_lost;
    logic  exp_locked;
  } vec_t;

  task automatic check_num(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One clock with the given inputs; outputs sampled 1 time unit after the edge
  task automatic step(input logic l, input logic e, input logic d, input logic c);
    load = l; en = e; din = d; clr = c;
    @(posedge clk);
    #1;
    if (bit_err) be_cnt++;
    if (lock_lost) begin
      lost_cnt++;
      check_bit("locked_low_on_lock_lost", locked, 1'b0);
    end
  endtask

  // Bench generator: new bit = XOR of tapped bits, shifted into bit 0
  task automatic gen_next(output logic b);
    b = ^(10'h240 & gen_state);
    gen_state = {gen_state[8:0], b};
  endtask

  // Load 10'h240 (with clr) and feed the 10 seed bits, checking exact lock timing
  task automatic start_and_seed(input string name);
    logic b;
    gen_state  = 10'h001;
    polynomial = 10'h240;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      gen_next(b);
      step(1'b0, 1'b1, b, 1'b0);
      if (i == 8) check_bit({name, "_unlocked_after_9"}, locked, 1'b0);
      if (i == 9) check_bit({name, "_locked_after_10"}, locked, 1'b1);
    end
  endtask

  vec_t vecs[6];

  initial begin
    logic b;
    logic flip;

    vecs[0] = '{"T1_clean",      200, -1, -1, -1, -1, 0, 0, 0, 1'b1};
    vecs[1] = '{"T2_one_err",    100, 50, -1, -1, -1, 1, 1, 0, 1'b1};
    vecs[2] = '{"T3_lock_loss",   80, 10, 20, 30, 40, 4, 4, 1, 1'b1};
    vecs[3] = '{"T4_split_win",  100, 10, 20, 30, 70, 4, 4, 0, 1'b1};
    vecs[4] = '{"win_boundary",  100, 61, 62, 63, 64, 4, 4, 0, 1'b1};
    vecs[5] = '{"loss_last_bit", 100, 60, 61, 62, 63, 4, 4, 1, 1'b1};

    rst = 1'b1; load = 1'b0; en = 1'b0; din = 1'b0; clr = 1'b0; polynomial = '0;
    be_cnt = 0; lost_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("reset_locked", locked, 1'b0);
    check_bit("reset_bit_err", bit_err, 1'b0);
    check_bit("reset_lock_lost", lock_lost, 1'b0);
    check_num("reset_err_count", int'(err_count), 0);
    rst = 1'b0;

    // Table-driven scenarios on the ERR_LIMIT=4 instance
    foreach (vecs[v]) begin
      start_and_seed(vecs[v].name);
      be_cnt = 0; lost_cnt = 0;
      for (int i = 0; i < vecs[v].nbits; i++) begin
        gen_next(b);
        flip = (i == vecs[v].f0) || (i == vecs[v].f1) || (i == vecs[v].f2) || (i == vecs[v].f3);
        step(1'b0, 1'b1, b ^ flip, 1'b0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check_bit({vecs[v].name, "_bit_err_idle"}, bit_err, 1'b0);
      check_num({vecs[v].name, "_err_count"}, int'(err_count), vecs[v].exp_err);
      check_num({vecs[v].name, "_bit_err_pulses"}, be_cnt, vecs[v].exp_bit_err);
      check_num({vecs[v].name, "_lock_lost_pulses"}, lost_cnt, vecs[v].exp_lost);
      check_bit({vecs[v].name, "_locked_end"}, locked, vecs[v].exp_locked);
      $display("vector %s: err_count=%0d bit_err=%0d lock_lost=%0d locked=%b",
               vecs[v].name, err_count, be_cnt, lost_cnt, locked);
    end

    // T5: zero polynomial keeps the checker idle
    polynomial = '0;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      check_bit("T5_idle_locked", locked, 1'b0);
      check_bit("T5_idle_bit_err", bit_err, 1'b0);
    end
    // Load edge with en high: that din must not count as a seed bit
    polynomial = 10'h240;
    gen_state  = 10'h001;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      gen_next(b);
      step(1'b0, 1'b1, b, 1'b0);
      if (i == 8) check_bit("T5_unlocked_after_9", locked, 1'b0);
      if (i == 9) check_bit("T5_locked_after_10", locked, 1'b1);
    end
    for (int i = 0; i < 20; i++) begin
      gen_next(b);
      step(1'b0, 1'b1, b, 1'b0);
    end
    check_num("T5_err_count", int'(err_count), 0);
    $display("sequence T5: locked=%b err_count=%0d", locked, err_count);

    // T6: saturation, clr, clr with mismatch, async reset (CNT_W=4, no lock drop)
    start_and_seed("T6");
    for (int i = 0; i < 40; i++) begin
      gen_next(b);
      step(1'b0, 1'b1, b ^ (i % 2 == 0), 1'b0);
    end
    check_num("T6_saturated", int'(err_count2), 15);
    check_bit("T6_still_locked", locked2, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_num("T6_clr", int'(err_count2), 0);
    gen_next(b);
    step(1'b0, 1'b1, ~b, 1'b1);
    check_num("T6_clr_with_err", int'(err_count2), 1);
    check_bit("T6_bit_err_pulse", bit_err2, 1'b1);
    rst = 1'b1;
    #1;
    check_bit("T6_rst_locked2", locked2, 1'b0);
    check_bit("T6_rst_bit_err2", bit_err2, 1'b0);
    check_num("T6_rst_err_count2", int'(err_count2), 0);
    check_bit("T6_rst_locked", locked, 1'b0);
    check_num("T6_rst_err_count", int'(err_count), 0);
    $display("sequence T6: after reset locked2=%b err_count2=%0d", locked2, err_count2);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
